tpumac_pipe: RTL
================

// Module: tpumac_pipe
// PURPOSE
//  Parametrised 2-stage pipelined signed MAC processing element for the systolic
//  TPU array. Forwards A east and B south with 1-cycle latency, as the current PE does.
//  Multiply (stage 1) and accumulate (stage 2) are registered separately to close timing at wider operands.
//  Adds an accumulation counter and an optional saturating accumulator with a sticky overflow flag.
// PARAMETERS
//  BITS_AB  8   signed width of A/B operands
//  BITS_C   16  signed accumulator width; must satisfy BITS_C >= 2*BITS_AB (elab-time check, $error)
//  CNT_W    8   width of acc_cnt
// PORTS
//  clk      in   1        clock, rising edge
//  rst_n    in   1        asynchronous, active-low reset
//  en       in   1        PE enable; 0 freezes every register in the block
//  WrEn     in   1        1: this beat loads Cin into accumulator instead of MAC
//  Ain      in   BITS_AB  signed A operand
//  Bin      in   BITS_AB  signed B operand
//  Cin      in   BITS_C   signed accumulator load value
//  Aout     out  BITS_AB  registered Ain (systolic forward)
//  Bout     out  BITS_AB  registered Bin (systolic forward)
//  Cout     out  BITS_C   accumulator
//  acc_cnt  out  CNT_W    MAC beats retired since last load
//  ovf      out  1        sticky overflow (TPUMAC_SAT_EN only; else const 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): Aout=Bout=0, Cout=0, acc_cnt=0, ovf=0; stage-1 regs cleared (op = load of 0, invalid).
//  - All updates occur only on edges with en=1. en=0 holds every reg, including the in-flight stage-1 op.
//  - A/B forward: Aout<=Ain, Bout<=Bin on each enabled edge (latency 1).
//  - Stage 1 (enabled edge): P1<=Ain*Bin (full 2*BITS_AB signed), W1<=WrEn, C1<=Cin, V1<=1.
//  - Stage 2 (enabled edge, V1=1): W1 ? Cout<=C1, acc_cnt<=0, ovf<=0
//      : Cout<=Cout+sext(P1), acc_cnt<=acc_cnt+1 (saturates at all-ones, no wrap).
//  - Latency Ain/Bin/Cin -> Cout: 2 enabled edges, for both load and MAC beats.
//  - Program order is kept: MAC at beat t then WrEn at t+1 shows MAC result, then Cin.
//  - First enabled edge after reset: V1=0, stage 2 holds Cout.
//  - Product sign-extended to BITS_C+1; sum computed in BITS_C+1 bits.
//  - Reset mid-stream drops the in-flight stage-1 op. Bench must reload with WrEn.
//  - No multicycle paths; one DSP multiply per PE.
// CONFIGURATION
//  TPUMAC_SAT_EN defined:
//    - Sum > 2^(BITS_C-1)-1 -> Cout = max positive; sum < -2^(BITS_C-1) -> Cout = min negative.
//    - Either clamp sets ovf=1, sticky until the next retired WrEn load or reset.
//  TPUMAC_SAT_EN undefined:
//    - Cout wraps modulo 2^BITS_C, matching legacy PE arithmetic.
//    - ovf tied to 0.
// TESTING (defaults; "edge" = enabled rising edge)
//  1 rst_n=0 mid-run -> Aout=Bout=Cout=acc_cnt=ovf=0 immediately; after release, first edge leaves Cout=0.
//  2 WrEn=1,Cin=100,Ain=5,Bin=7 on edge k -> Aout=5,Bout=7 after k; Cout=100,acc_cnt=0 after k+1.
//  3 After load 100, three MAC beats Ain=3,Bin=-4 -> Cout=88,76,64, acc_cnt=1,2,3 on successive edges.
//  4 en=0 for 5 cycles during test 3 -> Aout/Bout/Cout/acc_cnt frozen; resumption finishes at 64, no lost beat.
//  5 Load 32760, MAC 127*127 -> wrap build: Cout=-16647, ovf=0; SAT build: Cout=32767, ovf=1; next load clears ovf.
//  6 Random 10k beats vs. 2-deep golden model, including back-to-back WrEn/MAC -> exact Cout/acc_cnt match every edge.

Source files
------------

// File: rtl/tpumac_pipe.sv
// Two-stage pipelined signed MAC processing element for the systolic array.
// Optional saturating accumulator with sticky overflow: define TPUMAC_SAT_EN.
module tpumac_pipe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic [CNT_W-1:0]          acc_cnt,
  output logic                      ovf
);

  localparam int PW = 2 * BITS_AB;

  generate
    if (BITS_C < PW) begin : g_bad_width
      $error("tpumac_pipe: BITS_C must be at least 2*BITS_AB");
    end
  endgenerate

  logic signed [PW-1:0]     p1;
  logic signed [BITS_C-1:0] c1;
  logic                     w1;
  logic                     v1;
  logic signed [BITS_C-1:0] mac_res;

`ifdef TPUMAC_SAT_EN
  localparam int SW = BITS_C + 1;
  logic signed [SW-1:0] sum;
  logic                 mac_ovf;

  // One guard bit: the two top bits disagree exactly when the sum leaves BITS_C range.
  always_comb begin
    sum     = SW'(Cout) + SW'(p1);
    mac_ovf = sum[SW-1] ^ sum[SW-2];
    if (!mac_ovf)
      mac_res = sum[BITS_C-1:0];
    else if (sum[SW-1])
      mac_res = {1'b1, {(BITS_C-1){1'b0}}};
    else
      mac_res = {1'b0, {(BITS_C-1){1'b1}}};
  end
`else
  assign mac_res = Cout + BITS_C'(p1);
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Aout    <= '0;
      Bout    <= '0;
      p1      <= '0;
      c1      <= '0;
      w1      <= 1'b1;
      v1      <= 1'b0;
      Cout    <= '0;
      acc_cnt <= '0;
`ifdef TPUMAC_SAT_EN
      ovf     <= 1'b0;
`endif
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
      p1   <= PW'(Ain) * PW'(Bin);
      c1   <= Cin;
      w1   <= WrEn;
      v1   <= 1'b1;
      if (v1) begin
        if (w1) begin
          Cout    <= c1;
          acc_cnt <= '0;
`ifdef TPUMAC_SAT_EN
          ovf     <= 1'b0;
`endif
        end else begin
          Cout <= mac_res;
          if (acc_cnt != {CNT_W{1'b1}})
            acc_cnt <= acc_cnt + CNT_W'(1);
`ifdef TPUMAC_SAT_EN
          if (mac_ovf)
            ovf <= 1'b1;
`endif
        end
      end
    end
  end

endmodule
